// File: rtl/bank_req_fifo.sv
// Per-PE request queue toward the shared-memory bank arbiters: FWFT head with a
// one-hot bank request, occupancy thresholds and sticky error flags.
module bank_req_fifo #(
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_BANK_NUM = 16,
    parameter int BANK_SEL_W   = $clog2(MEM_BANK_NUM),
    parameter int FIFO_DEPTH   = 16,
    parameter int PTR_W        = $clog2(FIFO_DEPTH),
    parameter int AFULL_THRESH = FIFO_DEPTH - 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [BANK_SEL_W-1:0]   wr_bank,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    gnt,
    input  logic                    err_clr,
    output logic                    head_valid,
    output logic [BANK_SEL_W-1:0]   head_bank,
    output logic [DATA_WIDTH-1:0]   head_data,
    output logic [MEM_BANK_NUM-1:0] req_pea_to_bank,
    output logic [PTR_W:0]          count,
    output logic [PTR_W:0]          room_avail,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    overflow_err,
    output logic                    underflow_err,
    output logic                    bank_err
);

    localparam int ENTRY_W = BANK_SEL_W + DATA_WIDTH;
    localparam int CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]    DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]    AFULL_C    = CNT_W'(AFULL_THRESH);
    localparam logic [BANK_SEL_W:0] BANK_LIMIT = (BANK_SEL_W + 1)'(MEM_BANK_NUM);

    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d, room_q, room_d;
    logic             full_q, full_d, empty_q, empty_d, afull_q, afull_d;
    logic             ovf_q, ovf_d, unf_q, unf_d, bank_err_q, bank_err_d;
    logic             bank_ok, push, pop;

    assign bank_ok = {1'b0, wr_bank} < BANK_LIMIT;
    // full blocks the push even when a pop frees a slot in the same cycle
    assign push    = wr_en && !full_q && bank_ok;
    assign pop     = gnt && !empty_q;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        room_d  = DEPTH_C - count_d;
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
        afull_d = (count_d >= AFULL_C);
        // a new error wins over a simultaneous clear
        ovf_d      = (ovf_q      && !err_clr) || (wr_en && full_q);
        unf_d      = (unf_q      && !err_clr) || (gnt && empty_q);
        bank_err_d = (bank_err_q && !err_clr) || (wr_en && !bank_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            room_q     <= DEPTH_C;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            afull_q    <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            bank_err_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            room_q     <= room_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            afull_q    <= afull_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            bank_err_q <= bank_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {wr_bank, wr_data};
    end

    assign {head_bank, head_data} = mem_q[rd_ptr_q];
    assign head_valid = !empty_q;

    // request comes from registered state only, never from gnt
    always_comb begin
        req_pea_to_bank = '0;
        for (int i = 0; i < MEM_BANK_NUM; i++) begin
            req_pea_to_bank[i] = !empty_q && (head_bank == BANK_SEL_W'(i));
        end
    end

    assign count         = count_q;
    assign room_avail    = room_q;
    assign full          = full_q;
    assign empty         = empty_q;
    assign almost_full   = afull_q;
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;
    assign bank_err      = bank_err_q;

endmodule

// File: tb/tb_bank_req_fifo.sv
// Scoreboard bench for bank_req_fifo: stimulus queues expected head entries,
// a negedge monitor checks every entry the DUT pops on gnt.
module tb_bank_req_fifo;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // default instance: 16 banks, depth 16
    logic        wr_en, gnt, err_clr;
    logic [3:0]  wr_bank;
    logic [31:0] wr_data;
    logic        head_valid, full, empty, almost_full, overflow_err, underflow_err, bank_err;
    logic [3:0]  head_bank;
    logic [31:0] head_data;
    logic [15:0] req;
    logic [4:0]  count, room_avail;

    // second instance: 12 banks, so out-of-range indices are representable
    logic        b_wr_en, b_gnt, b_err_clr;
    logic [3:0]  b_wr_bank;
    logic [31:0] b_wr_data;
    logic        b_head_valid, b_full, b_empty, b_almost_full, b_overflow_err, b_underflow_err, b_bank_err;
    logic [3:0]  b_head_bank;
    logic [31:0] b_head_data;
    logic [11:0] b_req;
    logic [4:0]  b_count, b_room_avail;

    bank_req_fifo u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_bank(wr_bank), .wr_data(wr_data),
        .gnt(gnt), .err_clr(err_clr), .head_valid(head_valid), .head_bank(head_bank),
        .head_data(head_data), .req_pea_to_bank(req), .count(count), .room_avail(room_avail),
        .full(full), .empty(empty), .almost_full(almost_full), .overflow_err(overflow_err),
        .underflow_err(underflow_err), .bank_err(bank_err)
    );

    bank_req_fifo #(.MEM_BANK_NUM(12)) u_dut12 (
        .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_bank(b_wr_bank), .wr_data(b_wr_data),
        .gnt(b_gnt), .err_clr(b_err_clr), .head_valid(b_head_valid), .head_bank(b_head_bank),
        .head_data(b_head_data), .req_pea_to_bank(b_req), .count(b_count),
        .room_avail(b_room_avail), .full(b_full), .empty(b_empty), .almost_full(b_almost_full),
        .overflow_err(b_overflow_err), .underflow_err(b_underflow_err), .bank_err(b_bank_err)
    );

    int compared   = 0;
    int mismatched = 0;
    logic [35:0] exp_q [$];

    task automatic chk(input string name, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [3:0] bank, input logic [31:0] data);
        wr_en = 1'b1; wr_bank = bank; wr_data = data;
        exp_q.push_back({bank, data});
        step();
        wr_en = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_room"}, room_avail, 16);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_afull"}, almost_full, 0);
        chk({tag, "_hvalid"}, head_valid, 0);
        chk({tag, "_req"}, req, 0);
        chk({tag, "_errs"}, {overflow_err, underflow_err, bank_err}, 0);
    endtask

    // monitor: every gnt seen with a valid head is a pop at the coming edge
    always @(negedge clk) begin
        if (!rst && gnt && head_valid) begin
            logic [35:0] e;
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL pop_unexpected: got bank %0d data %0h expected no entry", head_bank, head_data);
            end else begin
                e = exp_q.pop_front();
                if ({head_bank, head_data} != e) begin
                    mismatched++;
                    $display("FAIL pop_entry: got bank %0d data %0h expected bank %0d data %0h",
                             head_bank, head_data, e[35:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; gnt = 1'b0; err_clr = 1'b0; wr_bank = '0; wr_data = '0;
        b_wr_en = 1'b0; b_gnt = 1'b0; b_err_clr = 1'b0; b_wr_bank = '0; b_wr_data = '0;
        step(); step();
        rst = 1'b0;
        chk_reset_state("rst0");

        // three entries, then three back-to-back grants
        push_one(4'd2, 32'hA);
        push_one(4'd5, 32'hB);
        push_one(4'd15, 32'hC);
        chk("t1_count", count, 3);
        chk("t1_req", req, 16'h0004);
        chk("t1_hdata", head_data, 32'hA);
        gnt = 1'b1;
        step(); chk("t1_req1", req, 16'h0020);
        step(); chk("t1_req2", req, 16'h8000);
        step(); chk("t1_req3", req, 16'h0000);
        gnt = 1'b0;
        chk("t1_empty", empty, 1);
        chk("t1_unf", underflow_err, 0);

        // fill to full, almost_full threshold at 12
        for (int i = 0; i < 16; i++) begin
            push_one(4'(i), 32'h100 + 32'(i));
            if (i == 10) chk("t2_afull11", almost_full, 0);
            if (i == 11) chk("t2_afull12", almost_full, 1);
        end
        chk("t2_full", full, 1);
        chk("t2_room", room_avail, 0);
        chk("t2_count", count, 16);
        // push while full with a simultaneous pop: push dropped
        wr_en = 1'b1; wr_bank = 4'd9; wr_data = 32'hDEAD; gnt = 1'b1;
        step();
        wr_en = 1'b0;
        chk("t2_ovf", overflow_err, 1);
        chk("t2_count15", count, 15);
        chk("t2_full0", full, 0);
        repeat (15) step();
        gnt = 1'b0;
        chk("t2_drained", empty, 1);
        chk("t2_q_empty", exp_q.size(), 0);
        err_clr = 1'b1; step(); err_clr = 1'b0;
        chk("t2_ovf_clr", overflow_err, 0);

        // steady push+pop at count 5, pointers wrap more than twice
        for (int i = 0; i < 5; i++) push_one(4'(i), 32'h200 + 32'(i));
        gnt = 1'b1;
        for (int i = 0; i < 40; i++) begin
            push_one(4'((i + 7) % 16), 32'h300 + 32'(i));
            chk("t3_count", count, 5);
        end
        repeat (5) step();
        gnt = 1'b0;
        chk("t3_empty", empty, 1);
        chk("t3_q_empty", exp_q.size(), 0);
        chk("t3_errs", {overflow_err, underflow_err}, 0);

        // illegal bank on the 12-bank instance
        b_wr_en = 1'b1; b_wr_bank = 4'd3; b_wr_data = 32'h1;
        step();
        b_wr_bank = 4'd13; b_wr_data = 32'h2;
        step();
        b_wr_en = 1'b0;
        chk("t4_bank_err", b_bank_err, 1);
        chk("t4_count", b_count, 1);
        chk("t4_req", b_req, 12'h008);
        b_wr_en = 1'b1; b_wr_bank = 4'd12; b_err_clr = 1'b1;
        step();
        b_wr_en = 1'b0;
        chk("t4_clr_vs_err", b_bank_err, 1);
        step();
        b_err_clr = 1'b0;
        chk("t4_cleared", b_bank_err, 0);
        chk("t4_count2", b_count, 1);

        // underflow, then confirm pointers did not move
        gnt = 1'b1; step(); gnt = 1'b0;
        chk("t5_unf", underflow_err, 1);
        chk("t5_count", count, 0);
        chk("t5_hvalid", head_valid, 0);
        push_one(4'd6, 32'h600);
        chk("t5_req", req, 16'h0040);
        gnt = 1'b1; step(); gnt = 1'b0;
        chk("t5_q_empty", exp_q.size(), 0);

        // reset with seven entries queued
        for (int i = 0; i < 7; i++) push_one(4'(i + 1), 32'h700 + 32'(i));
        chk("t5_count7", count, 7);
        rst = 1'b1; step(); rst = 1'b0;
        exp_q.delete();
        chk_reset_state("rst1");
        push_one(4'd1, 32'h800);
        chk("t5_post_rst_count", count, 1);
        gnt = 1'b1; step(); gnt = 1'b0;
        chk("t5_post_rst_empty", empty, 1);
        chk("t5_post_rst_q", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
